data_access_unit: RTL and testbench

- Sits between the pipeline MEM stage and the data port of the segmented memory (a2/wd/we/rd2).
- Accepts one load/store request at a time over a valid/ready handshake and waits out the synchronous RAM read latency.
- Range-checks addresses against the data map: RAM at 0..201, read-only IO flag at 202, unmapped at 203 and above.
- Returns read data or a fault, and drives a stall to the pipeline while busy.

---
 rtl/data_access_unit.sv | 115 +++++++++++
 tb/tb_data_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_access_unit.sv
// Load/store front end for the data port of the segmented memory: range-checks
// each request, waits out the synchronous read latency and returns data or a fault.
module data_access_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DATA_LIMIT   = 202,
    parameter int unsigned IO_ADDR      = 202
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             fault,
    output logic             stall,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT
    } state_t;

    localparam logic [1:0]       CNT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [WIDTH-1:0] LIMIT    = WIDTH'(DATA_LIMIT);
    localparam logic [WIDTH-1:0] IO       = WIDTH'(IO_ADDR);

    state_t           state, state_next;
    logic [WIDTH-1:0] addr_q, addr_next;
    logic [WIDTH-1:0] wdata_q, wdata_next;
    logic [WIDTH-1:0] rdata_q, rdata_next;
    logic [1:0]       cnt_q, cnt_next;
    logic             resp_valid_q, resp_valid_next;
    logic             fault_q, fault_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state        <= state_next;
            addr_q       <= addr_next;
            wdata_q      <= wdata_next;
            rdata_q      <= rdata_next;
            cnt_q        <= cnt_next;
            resp_valid_q <= resp_valid_next;
            fault_q      <= fault_next;
        end
    end

    always_comb begin
        state_next      = state;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        rdata_next      = rdata_q;
        cnt_next        = cnt_q;
        resp_valid_next = 1'b0;
        fault_next      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    // The IO flag is readable but not writable, so stores use the
                    // stricter bound and loads admit exactly one more address.
                    if (req_write ? (req_addr < LIMIT) : (req_addr <= IO)) begin
                        state_next = req_write ? WRITE : READ_WAIT;
                        cnt_next   = CNT_INIT;
                    end else begin
                        resp_valid_next = 1'b1;
                        fault_next      = 1'b1;
                        rdata_next      = '0;
                    end
                end
            end
            WRITE: begin
                state_next      = IDLE;
                resp_valid_next = 1'b1;
            end
            READ_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_next      = IDLE;
                    rdata_next      = mem_rd;
                    resp_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt_q - 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign stall      = (state != IDLE);
    assign mem_we     = (state == WRITE) && !reset;
    assign mem_a      = addr_q;
    assign mem_wd     = wdata_q;
    assign resp_valid = resp_valid_q;
    assign fault      = fault_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_data_access_unit.sv
// Scoreboard bench for data_access_unit: one instance at READ_LATENCY=1 and one
// at READ_LATENCY=3, each with its own behavioural memory model.
module tb_data_access_unit;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          due;
        logic        is_store;
        logic [7:0]  a;
        logic [31:0] old;
        logic        old_v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    logic        rv[2], rwr[2], rdy[2], rsp[2], flt[2], stl[2], we[2];
    logic [31:0] ra[2], rwd[2], rdat[2], ma[2], mwd[2];

    exp_t        sbq[2][$];
    logic [31:0] shadow[2][256];
    logic        shadow_v[2][256];
    logic [31:0] last_rd[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'd202) ? 32'h0000_0001 : {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input int g, input logic [31:0] a);
        if (a >= 32'd256) return '0;
        return shadow_v[g][a[7:0]] ? shadow[g][a[7:0]] : init_val(a);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0]  a1, a2, sel, mrd;
        logic [31:0]  mem[256];
        logic [255:0] written;
        exp_t         e;

        data_access_unit #(
            .WIDTH(32), .READ_LATENCY(LAT), .DATA_LIMIT(202), .IO_ADDR(202)
        ) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(rv[g]), .req_write(rwr[g]), .req_addr(ra[g]), .req_wdata(rwd[g]),
            .req_ready(rdy[g]), .resp_valid(rsp[g]), .resp_rdata(rdat[g]), .fault(flt[g]),
            .stall(stl[g]), .mem_we(we[g]), .mem_a(ma[g]), .mem_wd(mwd[g]), .mem_rd(mrd)
        );

        // Synchronous RAM model: data valid READ_LATENCY cycles after mem_a is presented.
        always @(posedge clk) begin
            a1 <= ma[g];
            a2 <= a1;
            if (mem_clr) written <= '0;
            else if (we[g] && ma[g] < 32'd256) begin
                mem[ma[g][7:0]]     <= mwd[g];
                written[ma[g][7:0]] <= 1'b1;
            end
        end

        always_comb begin
            sel = (LAT == 1) ? ma[g] : a2;
            mrd = '0;
            if (sel < 32'd256) mrd = written[sel[7:0]] ? mem[sel[7:0]] : init_val(sel);
        end

        always @(negedge clk) begin
            if (!reset && rsp[g]) begin
                if (sbq[g].size() == 0) begin
                    check($sformatf("unexpected_resp%0d", g), 32'(sbq[g].size()), 32'd1);
                end else begin
                    e = sbq[g].pop_front();
                    check($sformatf("resp_cycle%0d", g), 32'(cyc), 32'(e.due));
                    check($sformatf("fault%0d", g), 32'(flt[g]), 32'(e.fault));
                    check($sformatf("rdata%0d", g), rdat[g], e.rdata);
                end
            end
        end
    end

    task automatic drive(input int g, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int   lat;
        int   n;
        exp_t e;
        lat = (g == 0) ? 1 : 3;
        n = 0;
        @(negedge clk);
        rv[g] = 1'b1; rwr[g] = wr; ra[g] = a; rwd[g] = d;
        while (!rdy[g] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[g]) begin
            check("accept_timeout", 32'(rdy[g]), 32'd1);
            rv[g] = 1'b0;
            return;
        end
        e.is_store = 1'b0; e.a = a[7:0]; e.old = '0; e.old_v = 1'b0;
        if (wr && a < 32'd202) begin
            e.fault = 1'b0; e.rdata = last_rd[g]; e.due = cyc + 2; e.is_store = 1'b1;
            e.old = shadow[g][a[7:0]]; e.old_v = shadow_v[g][a[7:0]];
            shadow[g][a[7:0]] = d; shadow_v[g][a[7:0]] = 1'b1;
        end else if (!wr && a <= 32'd202) begin
            e.fault = 1'b0; e.rdata = ref_rd(g, a); e.due = cyc + lat + 1;
            last_rd[g] = e.rdata;
        end else begin
            e.fault = 1'b1; e.rdata = '0; e.due = cyc + 1;
            last_rd[g] = '0;
        end
        sbq[g].push_back(e);
        @(posedge clk);
        #1 rv[g] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain0", 32'(sbq[0].size()), 32'd0);
        check("drain1", 32'(sbq[1].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            rv[g] = 1'b0; rwr[g] = 1'b0; ra[g] = '0; rwd[g] = '0; last_rd[g] = '0;
            for (int i = 0; i < 256; i++) begin
                shadow[g][i] = '0; shadow_v[g][i] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_ready1", 32'(rdy[1]), 32'd1);
        check("rst_resp", 32'(rsp[0]), 32'd0);
        check("rst_fault", 32'(flt[0]), 32'd0);
        check("rst_stall", 32'(stl[0]), 32'd0);
        check("rst_we", 32'(we[0]), 32'd0);
        check("rst_addr", ma[0], 32'd0);
        check("rst_wd", mwd[0], 32'd0);
        check("rst_rdata", rdat[0], 32'd0);
        reset = 1'b0; mem_clr = 1'b0;

        // Store then load, latency 1
        drive(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        check("st_we", 32'(we[0]), 32'd1);
        check("st_addr", ma[0], 32'd5);
        check("st_wd", mwd[0], 32'hDEAD_BEEF);
        check("st_stall_t1", 32'(stl[0]), 32'd1);
        @(posedge clk); #1;
        check("st_stall_t2", 32'(stl[0]), 32'd0);
        check("st_we_t2", 32'(we[0]), 32'd0);
        drive(0, 1'b0, 32'd5, '0);

        // Latency 3 instance: stall held T+1..T+3
        drive(1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        drive(1, 1'b0, 32'd5, '0);
        check("l3_stall_t1", 32'(stl[1]), 32'd1);
        @(posedge clk); #1;
        check("l3_stall_t2", 32'(stl[1]), 32'd1);
        @(posedge clk); #1;
        check("l3_stall_t3", 32'(stl[1]), 32'd1);
        @(posedge clk); #1;
        check("l3_stall_t4", 32'(stl[1]), 32'd0);

        // IO flag: readable, store faults without write enable
        drive(0, 1'b0, 32'd202, '0);
        drive(0, 1'b1, 32'd202, 32'h1234_5678);
        check("io_st_we", 32'(we[0]), 32'd0);
        drive(1, 1'b0, 32'd202, '0);

        // Unmapped loads back to back
        drive(0, 1'b0, 32'd203, '0);
        drive(0, 1'b0, 32'hFFFF_FFFF, '0);

        // Store followed by load in its response cycle, boundary stores
        drive(0, 1'b1, 32'd101, 32'h1234_5678);
        drive(0, 1'b0, 32'd101, '0);
        drive(0, 1'b1, 32'd102, 32'h0BAD_F00D);
        drive(0, 1'b1, 32'd201, 32'hCAFE_0201);
        drive(0, 1'b1, 32'd202, 32'h5555_AAAA);
        drive(0, 1'b0, 32'd201, '0);
        drive(0, 1'b0, 32'd102, '0);
        drive(0, 1'b0, 32'd0, '0);
        wait_drain();

        // Reset in the WRITE cycle drops the store
        drive(0, 1'b1, 32'd10, 32'hAAAA_5555);
        wait_drain();
        drive(0, 1'b1, 32'd10, 32'hBAD0_BAD0);
        reset = 1'b1;
        #1;
        check("rst_mid_we", 32'(we[0]), 32'd0);
        while (sbq[0].size() != 0) begin
            e = sbq[0].pop_back();
            if (e.is_store) begin
                shadow[0][e.a] = e.old; shadow_v[0][e.a] = e.old_v;
            end
        end
        last_rd[0] = '0; last_rd[1] = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_ready", 32'(rdy[0]), 32'd1);
        check("rst_mid_resp", 32'(rsp[0]), 32'd0);
        check("rst_mid_rdata", rdat[0], 32'd0);
        drive(0, 1'b0, 32'd10, '0);

        // Mixed traffic on both instances
        for (int i = 0; i < 24; i++) begin
            int          g;
            logic        w;
            logic [31:0] a;
            g = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255))
                                             : 32'($urandom_range(195, 205));
            drive(g, w, a, $urandom);
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
